iq_agc: RTL and testbench

Digital automatic gain control for the I/Q baseband path, placed directly downstream of the I/Q IIR channel filter pair. It consumes the filtered I and Q samples and applies one common unsigned fixed-point gain with rounding and symmetric saturation. A closed loop measures mean |I|+|Q| over fixed windows and steps the gain one LSB per window toward a target band. Gain and lock status are exported to the control/status logic.

---
 rtl/iq_agc_pkg.sv | 15 +
 rtl/iq_gain_sat.sv | 77 +++++++
 rtl/iq_agc.sv | 168 ++++++++++++++++
 tb/tb_iq_agc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_agc_pkg.sv
// Shared types and constants for the I/Q automatic gain control.
package iq_agc_pkg;

    typedef enum logic [1:0] {
        StAccum,
        StUpdate,
        StSettle
    } agc_state_e;

    localparam int unsigned PipeLatency = 2;

    // After a gain step, this many samples already in the gain pipeline still carry the old gain.
    localparam int unsigned DiscardCount = PipeLatency;

endpackage

// File: rtl/iq_gain_sat.sv
// One channel of the gain path: stage 1 registers the product, and stage 2 registers the rounded,
// saturated result.
module iq_gain_sat
    import iq_agc_pkg::*;
#(
    parameter int unsigned IN_WID    = 10,
    parameter int unsigned OUT_WID   = 10,
    parameter int unsigned GAIN_WID  = 8,
    parameter int unsigned GAIN_FRAC = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       valid_in,
    input  logic signed [IN_WID-1:0]   data_in,
    input  logic [GAIN_WID-1:0]        gain,
    output logic                       valid_o,
    output logic signed [OUT_WID-1:0]  data_o
);

    localparam int unsigned ProdWid = IN_WID + GAIN_WID + 1;
    localparam int unsigned SumWid  = ProdWid + 1;

    localparam logic signed [SumWid-1:0] RndBias = SumWid'(2 ** (GAIN_FRAC - 1));
    localparam logic signed [SumWid-1:0] SatMax  = SumWid'(2 ** (OUT_WID - 1) - 1);
    localparam logic signed [SumWid-1:0] SatMin  = -SatMax;

    logic signed [ProdWid-1:0] din_ext;
    logic signed [ProdWid-1:0] gain_ext;
    logic signed [ProdWid-1:0] prod_d;
    logic signed [ProdWid-1:0] prod_q;
    logic                      valid1_q;

    logic signed [SumWid-1:0]  rnd_sum;
    logic signed [SumWid-1:0]  shifted;
    logic signed [OUT_WID-1:0] sat_d;
    logic signed [OUT_WID-1:0] data_q;
    logic                      valid2_q;

    assign din_ext  = ProdWid'(data_in);
    assign gain_ext = ProdWid'({1'b0, gain});
    assign prod_d   = din_ext * gain_ext;

    // Round half up, then clip symmetrically so the most negative code never appears.
    always_comb begin
        rnd_sum = SumWid'(prod_q) + RndBias;
        shifted = rnd_sum >>> GAIN_FRAC;
        if (shifted > SatMax) begin
            sat_d = OUT_WID'(SatMax);
        end else if (shifted < SatMin) begin
            sat_d = OUT_WID'(SatMin);
        end else begin
            sat_d = shifted[OUT_WID-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid1_q <= 1'b0;
            prod_q   <= '0;
            valid2_q <= 1'b0;
            data_q   <= '0;
        end else begin
            valid1_q <= valid_in;
            if (valid_in) begin
                prod_q <= prod_d;
            end
            valid2_q <= valid1_q;
            if (valid1_q) begin
                data_q <= sat_d;
            end
        end
    end

    assign valid_o = valid2_q;
    assign data_o  = data_q;

endmodule

// File: rtl/iq_agc.sv
// I/Q automatic gain control: a common gain with rounding and saturation, plus a windowed
// |I|+|Q| detector that steps the gain one LSB per window toward the target band.
module iq_agc
    import iq_agc_pkg::*;
#(
    parameter int unsigned IN_WID    = 10,
    parameter int unsigned OUT_WID   = 10,
    parameter int unsigned GAIN_WID  = 8,
    parameter int unsigned GAIN_FRAC = 5,
    parameter int unsigned GAIN_INIT = 32,
    parameter int unsigned GAIN_MIN  = 1,
    parameter int unsigned GAIN_MAX  = 255,
    parameter int unsigned WIN_LOG2  = 8,
    parameter int unsigned TARGET    = 256,
    parameter int unsigned HYST      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      valid_in,
    input  logic signed [IN_WID-1:0]  data_I_in,
    input  logic signed [IN_WID-1:0]  data_Q_in,
    output logic                      valid_o,
    output logic signed [OUT_WID-1:0] data_I_o,
    output logic signed [OUT_WID-1:0] data_Q_o,
    output logic [GAIN_WID-1:0]       gain_o,
    output logic                      lock_o
);

    localparam int unsigned MagWid  = OUT_WID + 1;
    localparam int unsigned AccWid  = MagWid + WIN_LOG2;
    localparam int unsigned DiscWid = $clog2(DiscardCount + 1);

    localparam logic [GAIN_WID-1:0] GainInit = GAIN_WID'(GAIN_INIT);
    localparam logic [GAIN_WID-1:0] GainMin  = GAIN_WID'(GAIN_MIN);
    localparam logic [GAIN_WID-1:0] GainMax  = GAIN_WID'(GAIN_MAX);
    localparam logic [MagWid-1:0]   BandLo   = MagWid'(TARGET - HYST);
    localparam logic [MagWid-1:0]   BandHi   = MagWid'(TARGET + HYST);
    localparam logic [DiscWid-1:0]  DiscLast = DiscWid'(DiscardCount - 1);

    logic valid_i_w;
    logic valid_q_w;

    agc_state_e          state_q, state_d;
    logic [AccWid-1:0]   acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [DiscWid-1:0]  disc_q, disc_d;
    logic [GAIN_WID-1:0] gain_q, gain_d;
    logic                lock_q, lock_d;

    logic signed [MagWid-1:0] i_ext;
    logic signed [MagWid-1:0] q_ext;
    logic [MagWid-1:0]        abs_i;
    logic [MagWid-1:0]        abs_q;
    logic [MagWid-1:0]        mag;
    logic [MagWid-1:0]        mean;
    logic                     in_band;

    iq_gain_sat #(
        .IN_WID    (IN_WID),
        .OUT_WID   (OUT_WID),
        .GAIN_WID  (GAIN_WID),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_gain_i (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (valid_in),
        .data_in  (data_I_in),
        .gain     (gain_q),
        .valid_o  (valid_i_w),
        .data_o   (data_I_o)
    );

    iq_gain_sat #(
        .IN_WID    (IN_WID),
        .OUT_WID   (OUT_WID),
        .GAIN_WID  (GAIN_WID),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_gain_q (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_in (valid_in),
        .data_in  (data_Q_in),
        .gain     (gain_q),
        .valid_o  (valid_q_w),
        .data_o   (data_Q_o)
    );

    // Both channels carry the same strobe; combining them keeps either one from dangling.
    assign valid_o = valid_i_w & valid_q_w;

    always_comb begin
        i_ext   = MagWid'(data_I_o);
        q_ext   = MagWid'(data_Q_o);
        abs_i   = i_ext[MagWid-1] ? -i_ext : i_ext;
        abs_q   = q_ext[MagWid-1] ? -q_ext : q_ext;
        mag     = abs_i + abs_q;
        mean    = acc_q[AccWid-1:WIN_LOG2];
        in_band = (mean >= BandLo) && (mean <= BandHi);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disc_d  = disc_q;
        gain_d  = gain_q;
        lock_d  = lock_q;
        unique case (state_q)
            StAccum: begin
                if (valid_o) begin
                    acc_d = acc_q + AccWid'(mag);
                    cnt_d = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                lock_d = in_band;
                if (en) begin
                    if (mean > BandHi && gain_q > GainMin) begin
                        gain_d = gain_q - 1'b1;
                    end else if (mean < BandLo && gain_q < GainMax) begin
                        gain_d = gain_q + 1'b1;
                    end
                end
                acc_d   = '0;
                cnt_d   = '0;
                disc_d  = '0;
                state_d = StSettle;
            end
            StSettle: begin
                if (valid_o) begin
                    if (disc_q == DiscLast) begin
                        disc_d  = '0;
                        state_d = StAccum;
                    end else begin
                        disc_d = disc_q + 1'b1;
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            disc_q  <= '0;
            gain_q  <= GainInit;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disc_q  <= disc_d;
            gain_q  <= gain_d;
            lock_q  <= lock_d;
        end
    end

    assign gain_o = gain_q;
    assign lock_o = lock_q;

endmodule

// File: tb/tb_iq_agc.sv
// Directed bench for iq_agc: gain path, rounding and saturation corners, loop convergence,
// freeze, sparse traffic and mid-window reset.
module tb_iq_agc;

    logic              clk;
    logic              reset_n;
    logic              en;
    logic              en_off;
    logic              valid_in;
    logic signed [9:0] data_I_in;
    logic signed [9:0] data_Q_in;

    logic              valid_o;
    logic signed [9:0] data_I_o;
    logic signed [9:0] data_Q_o;
    logic [7:0]        gain_o;
    logic              lock_o;

    logic              r_valid;
    logic signed [9:0] r_data_I;
    logic signed [9:0] r_data_Q;
    logic [7:0]        r_gain;
    logic              r_lock;

    logic              s_valid;
    logic signed [9:0] s_data_I;
    logic signed [9:0] s_data_Q;
    logic [7:0]        s_gain;
    logic              s_lock;

    int n_checks;
    int n_errors;

    iq_agc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .valid_in  (valid_in),
        .data_I_in (data_I_in),
        .data_Q_in (data_Q_in),
        .valid_o   (valid_o),
        .data_I_o  (data_I_o),
        .data_Q_o  (data_Q_o),
        .gain_o    (gain_o),
        .lock_o    (lock_o)
    );

    iq_agc #(.GAIN_INIT(48)) dut_r (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en_off),
        .valid_in  (valid_in),
        .data_I_in (data_I_in),
        .data_Q_in (data_Q_in),
        .valid_o   (r_valid),
        .data_I_o  (r_data_I),
        .data_Q_o  (r_data_Q),
        .gain_o    (r_gain),
        .lock_o    (r_lock)
    );

    iq_agc #(.GAIN_INIT(255)) dut_s (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en_off),
        .valid_in  (valid_in),
        .data_I_in (data_I_in),
        .data_Q_in (data_Q_in),
        .valid_o   (s_valid),
        .data_I_o  (s_data_I),
        .data_Q_o  (s_data_Q),
        .gain_o    (s_gain),
        .lock_o    (s_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One-cycle sample; returns just after the edge where it should appear at the output.
    task automatic send_one(input int i, input int q);
        @(negedge clk);
        valid_in  = 1'b1;
        data_I_in = 10'(i);
        data_Q_in = 10'(q);
        @(posedge clk);
        #1;
        check_eq("valid_early", int'(valid_o), 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_eq("valid_lat2", int'(valid_o), 1);
    endtask

    // Runs traffic (one valid every 'stride' cycles) and checks each gain step against the
    // expected edge; gain should walk 32 -> 56, then lock one window later.
    task automatic run_loop(input int stride, input int first_edge, input int interval,
                            input string tag);
        int n;
        int model_gain;
        int lock_edge;
        int limit;
        n          = 0;
        model_gain = 32;
        lock_edge  = -1;
        limit      = first_edge + interval * 24 + interval / 2;
        for (int e = 1; e <= limit; e++) begin
            @(negedge clk);
            valid_in = ((e - 1) % stride == 0);
            @(posedge clk);
            #1;
            if (int'(gain_o) != model_gain) begin
                check_eq({tag, "_step"}, int'(gain_o), model_gain + 1);
                check_eq({tag, "_edge"}, e, first_edge + interval * n);
                model_gain = model_gain + 1;
                n++;
            end
            if (lock_o && lock_edge < 0) begin
                lock_edge = e;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        check_eq({tag, "_nsteps"}, n, 24);
        check_eq({tag, "_gain"}, int'(gain_o), 56);
        check_eq({tag, "_lock"}, int'(lock_o), 1);
        check_eq({tag, "_lock_edge"}, lock_edge, first_edge + interval * 24);
        check_eq({tag, "_dataI"}, int'(data_I_o), 112);
        check_eq({tag, "_dataQ"}, int'(data_Q_o), 112);
    endtask

    initial begin
        int changes;
        int lock_hi;
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        en        = 1'b0;
        en_off    = 1'b0;
        valid_in  = 1'b0;
        data_I_in = '0;
        data_Q_in = '0;

        do_reset();
        check_eq("rst_valid", int'(valid_o), 0);
        check_eq("rst_dataI", int'(data_I_o), 0);
        check_eq("rst_dataQ", int'(data_Q_o), 0);
        check_eq("rst_gain", int'(gain_o), 32);
        check_eq("rst_lock", int'(lock_o), 0);
        check_eq("rst_gain_r", int'(r_gain), 48);
        check_eq("rst_gain_s", int'(s_gain), 255);

        // Unity gain passes samples straight through.
        send_one(100, -50);
        check_eq("unity_I", int'(data_I_o), 100);
        check_eq("unity_Q", int'(data_Q_o), -50);
        check_eq("unity_gain", int'(gain_o), 32);
        check_eq("unity_lock", int'(lock_o), 0);
        @(posedge clk);
        #1;
        check_eq("hold_valid", int'(valid_o), 0);
        check_eq("hold_I", int'(data_I_o), 100);

        // Gain 48 (1.5): 3 -> 4.5 -> 5, -3 -> -4.5 -> -4, 1 -> 2, -1 -> -1.
        send_one(3, 1);
        check_eq("rnd_pos_I", int'(r_data_I), 5);
        check_eq("rnd_pos_Q", int'(r_data_Q), 2);
        send_one(-3, -1);
        check_eq("rnd_neg_I", int'(r_data_I), -4);
        check_eq("rnd_neg_Q", int'(r_data_Q), -1);
        check_eq("unity_neg_I", int'(data_I_o), -3);

        // Gain 255 saturates; -512 clips to -511 even at unity gain.
        send_one(511, 0);
        check_eq("sat_pos_I", int'(s_data_I), 511);
        check_eq("sat_zero_Q", int'(s_data_Q), 0);
        check_eq("unity_max_I", int'(data_I_o), 511);
        send_one(-512, -512);
        check_eq("sat_neg_I", int'(s_data_I), -511);
        check_eq("sat_neg_Q", int'(s_data_Q), -511);
        check_eq("unity_min_I", int'(data_I_o), -511);

        // Continuous I=Q=64: mean = 4*gain, so the loop climbs to 56 (mean 224).
        do_reset();
        en        = 1'b1;
        data_I_in = 10'sd64;
        data_Q_in = 10'sd64;
        run_loop(1, 259, 259, "conv");

        // Frozen loop: same traffic, gain never moves and mean 128 never locks.
        do_reset();
        en      = 1'b0;
        changes = 0;
        lock_hi = 0;
        for (int e = 0; e < 3 * 259 + 10; e++) begin
            @(negedge clk);
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (gain_o != 8'd32) changes++;
            if (lock_o) lock_hi++;
        end
        check_eq("frz_changes", changes, 0);
        check_eq("frz_lock_cycles", lock_hi, 0);
        check_eq("frz_gain", int'(gain_o), 32);

        // One valid in three: no sample lands in the UPDATE cycle, so a window spans
        // 256 + 2 discards = 258 valid samples = 774 cycles.
        do_reset();
        en = 1'b1;
        run_loop(3, 769, 774, "sparse");

        // Reset in the middle of an accumulation window with data in flight.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_in = 1'b1;
        end
        @(negedge clk);
        reset_n  = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", int'(valid_o), 0);
        check_eq("mid_rst_I", int'(data_I_o), 0);
        check_eq("mid_rst_Q", int'(data_Q_o), 0);
        check_eq("mid_rst_gain", int'(gain_o), 32);
        check_eq("mid_rst_lock", int'(lock_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("drop_valid1", int'(valid_o), 0);
        @(posedge clk);
        #1;
        check_eq("drop_valid2", int'(valid_o), 0);
        check_eq("drop_I", int'(data_I_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
